// File: rtl/riscv_dmem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_dmem_pkg
// Shared constants and types for the data-memory subsystem:
//   - MMIO register offsets within the 16-byte MMIO window
//   - CONSOLE_STATUS bit positions
//   - address-region enum used by the top-level decoder
// -----------------------------------------------------------------------------
package riscv_dmem_pkg;

    // Byte offsets inside the MMIO window (dmem_addr[3:0], low two bits zero).
    localparam logic [3:0] OFS_CYCLE          = 4'h0;
    localparam logic [3:0] OFS_CONSOLE_TX     = 4'h4;
    localparam logic [3:0] OFS_CONSOLE_STATUS = 4'h8;
    localparam logic [3:0] OFS_HALT           = 4'hC;

    // CONSOLE_STATUS layout.
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_FAULT     = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 8;   // count field occupies bits[11:4]

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_UNMAPPED
    } region_e;

endpackage : riscv_dmem_pkg

// File: rtl/dmem_console_fifo.sv
// -----------------------------------------------------------------------------
// dmem_console_fifo
// Synchronous FIFO feeding the console drain port.
//   clk, nrst      : clock, async active-low reset
//   i_push         : enqueue request (dropped and flagged when full w/o pop)
//   i_push_data    : byte to enqueue
//   i_pop          : dequeue request (ignored while empty)
//   i_clr_ovf      : clear the sticky overflow flag
//   o_head_data    : head entry, 0 while empty
//   o_full/o_empty : occupancy flags
//   o_count        : number of stored entries, 0..DEPTH
//   o_overflow     : sticky "push lost" flag
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
module dmem_console_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_clr_ovf,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push  = i_push & (~w_full | w_pop);

    // NOTE: storage carries no reset; the empty flag masks stale entries, so
    // clearing the array on reset would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Losing a byte takes priority over a clear in the same cycle.
            if (i_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_head_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;

endmodule : dmem_console_fifo

// File: rtl/riscv_dmem_subsys.sv
// -----------------------------------------------------------------------------
// riscv_dmem_subsys
// Data-memory subsystem on the core's memory-stage bus. Reads are purely
// combinational (the core registers read data at M/W); writes land on the
// rising clock edge.
//
// Memory map:
//   [0, RAM_DEPTH*4)     word RAM (dmem_addr[1:0] ignored)
//   MMIO_BASE + 0x0      CYCLE          free-running counter, writable
//   MMIO_BASE + 0x4      CONSOLE_TX     push byte, reads 0
//   MMIO_BASE + 0x8      CONSOLE_STATUS count/fault/overflow/empty/full,
//                                       any write clears the sticky flags
//   MMIO_BASE + 0xC      HALT           first write latches code and halts
//   anything else        reads 0, writes ignored
//
// Ports:
//   clk, nrst                       clock, async active-low reset
//   dmem_addr/data_in/wr_en         memory-stage bus from the core
//   dmem_data_out                   combinational read data
//   console_data/valid/ready        console FIFO drain port
//   halt, halt_code                 sticky end-of-test flag and its code
//   cycle_count                     counter value
//   access_fault                    only with DMEM_BOUNDS_CHECK_EN
//
// Build option DMEM_BOUNDS_CHECK_EN: adds a sticky access_fault flag (set by
// unmapped writes or any misaligned address, visible at CONSOLE_STATUS bit3)
// and suppresses misaligned writes.
// -----------------------------------------------------------------------------
module riscv_dmem_subsys
    import riscv_dmem_pkg::*;
#(
    parameter int                    WORD_WIDTH = 32,
    parameter int                    RAM_DEPTH  = 1024,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [WORD_WIDTH-1:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] dmem_addr,
    input  logic [WORD_WIDTH-1:0] dmem_data_in,
    input  logic                  dmem_wr_en,
    output logic [WORD_WIDTH-1:0] dmem_data_out,
    output logic [7:0]            console_data,
    output logic                  console_valid,
    input  logic                  console_ready,
    output logic                  halt,
    output logic [WORD_WIDTH-1:0] halt_code,
`ifdef DMEM_BOUNDS_CHECK_EN
    output logic                  access_fault,
`endif
    output logic [WORD_WIDTH-1:0] cycle_count
);

    localparam int                    RAM_AW     = $clog2(RAM_DEPTH);
    localparam int                    FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WORD_WIDTH-1:0] RAM_BYTES  = WORD_WIDTH'(RAM_DEPTH * 4);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    region_e           w_region;
    logic [3:0]        w_ofs;
    logic [RAM_AW-1:0] w_ram_idx;

    // NOTE: every always_comb assigns its outputs a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        w_region = REG_UNMAPPED;
        if (dmem_addr < RAM_BYTES) begin
            w_region = REG_RAM;
        end else if (dmem_addr[WORD_WIDTH-1:4] == MMIO_BASE[WORD_WIDTH-1:4]) begin
            w_region = REG_MMIO;
        end
    end

    assign w_ofs     = {dmem_addr[3:2], 2'b00};
    assign w_ram_idx = dmem_addr[RAM_AW+1:2];

    // ------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------
    logic w_wr;
    logic w_fault_bit;

`ifdef DMEM_BOUNDS_CHECK_EN
    logic w_misaligned;
    assign w_misaligned = |dmem_addr[1:0];
    assign w_wr         = dmem_wr_en & ~w_misaligned;
`else
    // Byte offset is meaningless without the bounds checker.
    logic w_unused;
    assign w_unused = ^dmem_addr[1:0];
    assign w_wr     = dmem_wr_en;
`endif

    logic w_ram_we;
    logic w_mmio_we;
    logic w_cycle_we;
    logic w_tx_we;
    logic w_status_we;
    logic w_halt_we;

    assign w_ram_we    = w_wr && (w_region == REG_RAM);
    assign w_mmio_we   = w_wr && (w_region == REG_MMIO);
    assign w_cycle_we  = w_mmio_we && (w_ofs == OFS_CYCLE);
    assign w_tx_we     = w_mmio_we && (w_ofs == OFS_CONSOLE_TX);
    assign w_status_we = w_mmio_we && (w_ofs == OFS_CONSOLE_STATUS);
    assign w_halt_we   = w_mmio_we && (w_ofs == OFS_HALT);

    // ------------------------------------------------------------------
    // Word RAM: write on the edge, read combinationally, so a same-cycle
    // read of the written word still returns the old contents.
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] r_ram [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= dmem_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and halt register
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] r_cycle;
    logic                  r_halt;
    logic [WORD_WIDTH-1:0] r_halt_code;

    // r_halt is still 0 on the edge that writes HALT, so that edge counts
    // once more before the counter freezes.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cycle <= '0;
        end else if (w_cycle_we) begin
            r_cycle <= dmem_data_in;
        end else if (!r_halt) begin
            r_cycle <= r_cycle + WORD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_halt      <= 1'b0;
            r_halt_code <= '0;
        end else if (w_halt_we && !r_halt) begin
            r_halt      <= 1'b1;
            r_halt_code <= dmem_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [FIFO_CNT_W-1:0] w_fifo_count;
    logic                  w_fifo_overflow;

    dmem_console_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_console_fifo (
        .clk         (clk),
        .nrst        (nrst),
        .i_push      (w_tx_we),
        .i_push_data (dmem_data_in[7:0]),
        .i_pop       (console_ready),
        .i_clr_ovf   (w_status_we),
        .o_head_data (console_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count),
        .o_overflow  (w_fifo_overflow)
    );

    assign console_valid = ~w_fifo_empty;

    // ------------------------------------------------------------------
    // Optional access-fault flag
    // ------------------------------------------------------------------
`ifdef DMEM_BOUNDS_CHECK_EN
    logic r_access_fault;

    // The bus has no read strobe, so a misaligned address counts as an
    // access on every cycle it is presented. Setting wins over clearing.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_access_fault <= 1'b0;
        end else if (w_misaligned || (dmem_wr_en && (w_region == REG_UNMAPPED))) begin
            r_access_fault <= 1'b1;
        end else if (w_status_we) begin
            r_access_fault <= 1'b0;
        end
    end

    assign access_fault = r_access_fault;
    assign w_fault_bit  = r_access_fault;
`else
    assign w_fault_bit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] w_status;

    always_comb begin
        w_status                                 = '0;
        w_status[ST_COUNT_LSB +: FIFO_CNT_W]     = w_fifo_count;
        w_status[ST_FAULT]                       = w_fault_bit;
        w_status[ST_OVERFLOW]                    = w_fifo_overflow;
        w_status[ST_EMPTY]                       = w_fifo_empty;
        w_status[ST_FULL]                        = w_fifo_full;
    end

    always_comb begin
        dmem_data_out = '0;
        unique case (w_region)
            REG_RAM: dmem_data_out = r_ram[w_ram_idx];
            REG_MMIO: begin
                case (w_ofs)
                    OFS_CYCLE:          dmem_data_out = r_cycle;
                    OFS_CONSOLE_STATUS: dmem_data_out = w_status;
                    OFS_HALT:           dmem_data_out = r_halt_code;
                    default:            dmem_data_out = '0;  // CONSOLE_TX
                endcase
            end
            default: dmem_data_out = '0;
        endcase
    end

    assign halt        = r_halt;
    assign halt_code   = r_halt_code;
    assign cycle_count = r_cycle;

endmodule : riscv_dmem_subsys
